// File: rtl/alu_seq.sv
// Handshaked multi-cycle execute-stage ALU: single-cycle integer ops plus iterative RV M-extension multiply/divide.
// Optional divider enabled by defining ALU_SEQ_DIV_EN; without it ops 14-17 return out_illegal.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_illegal
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SRL    = 5'd3;
    localparam logic [4:0] OP_SRA    = 5'd4;
    localparam logic [4:0] OP_AND    = 5'd5;
    localparam logic [4:0] OP_OR     = 5'd6;
    localparam logic [4:0] OP_XOR    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd10;
    localparam logic [4:0] OP_MULH   = 5'd11;
    localparam logic [4:0] OP_MULHSU = 5'd12;
    localparam logic [4:0] OP_MULHU  = 5'd13;
    localparam logic [4:0] OP_DIV    = 5'd14;
    localparam logic [4:0] OP_DIVU   = 5'd15;
    localparam logic [4:0] OP_REM    = 5'd16;
    localparam logic [4:0] OP_REMU   = 5'd17;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [WIDTH-1:0] alu_res(input logic [4:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic [SHW-1:0]          sh;
        sa = a;
        sb = b;
        sh = b[SHW-1:0];
        case (f)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = sa >>> sh;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = '0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        mag = (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic is_illegal(input logic [4:0] f);
`ifdef ALU_SEQ_DIV_EN
        is_illegal = (f > OP_REMU);
`else
        is_illegal = (f > OP_MULHU);
`endif
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               ill_q, ill_d;
    logic [4:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_q, neg_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    // acc holds {partial high, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mstep;
    logic [2*WIDTH-1:0] mfix;
    logic               a_sg, b_sg;

    assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mstep = {msum, acc_q[WIDTH-1:1]};
    assign mfix  = neg_q ? -mstep : mstep;
    assign a_sg  = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign b_sg  = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0]   a_q, a_d;
    logic               bz_q, bz_d;
    logic [WIDTH:0]     dshift;
    logic [WIDTH:0]     ddiff;
    logic [2*WIDTH-1:0] dstep;
    logic [WIDTH-1:0]   dmag;
    logic               quot_sel;

    assign dshift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign ddiff    = dshift - {1'b0, opb_q};
    assign dstep    = ddiff[WIDTH] ? {dshift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign quot_sel = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign dmag     = quot_sel ? dstep[WIDTH-1:0] : dstep[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ill_d   = ill_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
`ifdef ALU_SEQ_DIV_EN
        a_d     = a_q;
        bz_d    = bz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d  = op;
                    cnt_d = '0;
                    case (op)
                        OP_MUL, OP_MULH, OP_DIV: neg_d = in1[WIDTH-1] ^ in2[WIDTH-1];
                        OP_MULHSU, OP_REM:       neg_d = in1[WIDTH-1];
                        default:                 neg_d = 1'b0;
                    endcase
                    if (is_illegal(op)) begin
                        out_d   = '0;
                        ill_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (op >= OP_MUL && op <= OP_MULHU) begin
                        acc_d   = {{WIDTH{1'b0}}, mag(in2, b_sg)};
                        opb_d   = mag(in1, a_sg);
                        state_d = S_MUL;
`ifdef ALU_SEQ_DIV_EN
                    end else if (op >= OP_DIV && op <= OP_REMU) begin
                        acc_d   = {{WIDTH{1'b0}}, mag(in1, a_sg)};
                        opb_d   = mag(in2, b_sg);
                        a_d     = in1;
                        bz_d    = (in2 == '0);
                        state_d = S_DIV;
`endif
                    end else begin
                        out_d   = alu_res(op, in1, in2);
                        ill_d   = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                acc_d = mstep;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    out_d   = (op_q == OP_MUL) ? mfix[WIDTH-1:0] : mfix[2*WIDTH-1:WIDTH];
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
`ifdef ALU_SEQ_DIV_EN
            S_DIV: begin
                acc_d = dstep;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    if (bz_q) out_d = quot_sel ? '1 : a_q;
                    else      out_d = neg_q ? -dmag : dmag;
                    ill_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ill_q   <= ill_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q  <= op_d;
        acc_q <= acc_d;
        opb_q <= opb_d;
        neg_q <= neg_d;
        cnt_q <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
        a_q   <= a_d;
        bz_q  <= bz_d;
`endif
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out         = out_q;
    assign out_illegal = ill_q;

endmodule
